// File: rtl/seg_scan.sv
// Multiplexed hex display scanner with double-buffered frame updates.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     in_dp,
  output logic [3:0]            seg_nibble,
  output logic [DIGITS-1:0]     digit_en_n,
  output logic                  dp_n,
  output logic                  frame_done,
  output logic                  scan_state
);

  // Handshake: a word is taken on any rising edge where in_valid && in_ready;
  // in_ready is high exactly when the pending buffer is empty.

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  typedef enum logic {BLANK = 1'b0, SCAN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend_data, disp_data;
  logic [DIGITS-1:0]     pend_dp, disp_dp;
  logic                  pend_full;
  logic                  tick, frame_end, accept, commit;

  assign tick      = (cnt == CNT_MAX);
  assign frame_end = tick && (idx == IDX_MAX);
  assign accept    = in_valid && !pend_full;
  assign commit    = frame_end && pend_full;

  assign in_ready   = !pend_full;
  assign frame_done = commit;
  assign scan_state = (state_q == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Commit requires a full pending buffer and accept requires an empty one,
  // so the two never collide in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else if (commit) begin
      pend_full <= 1'b0;
      disp_data <= pend_data;
      disp_dp   <= pend_dp;
    end else if (accept) begin
      pend_full <= 1'b1;
      pend_data <= in_data;
      pend_dp   <= in_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BLANK;
    else        state_q <= state_d;
  end

`ifdef SEG_SCAN_LZB_EN
  // A digit stays visible if it or any higher digit is nonzero, if its
  // decimal point is lit, or if it is digit 0.
  logic [DIGITS-1:0] show;
  logic              seen;
  always_comb begin
    show = '0;
    seen = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seen    = seen || (disp_data[4*k +: 4] != 4'h0);
      show[k] = seen || disp_dp[k] || (k == 0);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    digit_en_n = '1;
    dp_n       = 1'b1;
    seg_nibble = 4'h0;
    if (state_q == BLANK && commit) state_d = SCAN;
    if (state_q == SCAN) begin
      seg_nibble = disp_data[{idx, 2'b00} +: 4];
`ifdef SEG_SCAN_LZB_EN
      if (show[idx]) begin
        digit_en_n = ~(DIGITS'(1) << idx);
        dp_n       = ~disp_dp[idx];
      end
`else
      digit_en_n = ~(DIGITS'(1) << idx);
      dp_n       = ~disp_dp[idx];
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan (DIGITS=8, DIV=4): driver pushes accepted words into a
// queue; a negedge monitor predicts scan outputs from cycle arithmetic.
module tb_seg_scan;
  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [7:0]  in_dp = '0;
  logic [3:0]  seg_nibble;
  logic [7:0]  digit_en_n;
  logic        dp_n;
  logic        frame_done;
  logic        scan_state;

  seg_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dp(in_dp), .seg_nibble(seg_nibble),
    .digit_en_n(digit_en_n), .dp_n(dp_n), .frame_done(frame_done),
    .scan_state(scan_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int c = 0;
  int commit_cyc = -1;
  int acc_cyc = -1;
  logic [39:0] exp_q[$];
  logic [31:0] disp_data = '0;
  logic [7:0]  disp_dp = '0;
  bit          scan = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  // Cycles elapsed since reset release; slot and frame position derive from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) c <= 0;
    else        c <= c + 1;
  end

  always @(negedge clk or negedge rst_n) begin : monitor
    int          slot;
    bit          bnd;
    bit          shown;
    logic [7:0]  e_en;
    logic [3:0]  e_nib;
    logic        e_dp;
    if (!rst_n) begin
      exp_q.delete();
      scan      = 1'b0;
      disp_data = '0;
      disp_dp   = '0;
    end else begin
      slot  = (c / DIV) % DIGITS;
      bnd   = (c % FRAME) == FRAME - 1;
      e_en  = 8'hFF;
      e_nib = 4'h0;
      e_dp  = 1'b1;
      if (scan) begin
        e_nib = disp_data[slot*4 +: 4];
        shown = 1'b1;
`ifdef SEG_SCAN_LZB_EN
        shown = (slot == 0) || disp_dp[slot] || ((disp_data >> (4 * slot)) != 0);
`endif
        if (shown) begin
          e_en = ~(8'd1 << slot);
          e_dp = ~disp_dp[slot];
        end
      end
      check("digit_en_n", {24'd0, digit_en_n}, {24'd0, e_en});
      check("seg_nibble", {28'd0, seg_nibble}, {28'd0, e_nib});
      check("dp_n", {31'd0, dp_n}, {31'd0, e_dp});
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() == 0});
      check("frame_done", {31'd0, frame_done}, {31'd0, bnd && exp_q.size() > 0});
      if (bnd && exp_q.size() > 0) begin
        {disp_dp, disp_data} = exp_q.pop_front();
        scan       = 1'b1;
        commit_cyc = c;
      end
    end
  end

  task automatic send(input logic [31:0] word, input logic [7:0] dp);
    int waited = 0;
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = word;
    in_dp    = dp;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        acc_cyc = c;
      end else begin
        waited++;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({dp, word});
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      in_dp    = 8'($urandom);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"}, {24'd0, digit_en_n}, 32'h0000_00FF);
    check({tag, "_dp"}, {31'd0, dp_n}, 32'd1);
    check({tag, "_nib"}, {28'd0, seg_nibble}, 32'd0);
    check({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic wait_pos(input int pos);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((c % FRAME) != pos && n < 4 * FRAME);
    if ((c % FRAME) != pos) check("wait_pos", c % FRAME, pos);
  endtask

  initial begin
    int first_commit;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset_init");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Idle: display stays blank and frame_done never fires.
    repeat (100) @(posedge clk);

    // Word 1 then word 2 offered while word 1 is still pending.
    send(32'h1234ABCD, 8'h01);
    send(32'h5678_0F0F, 8'h80);
    first_commit = commit_cyc;
    check("accept_after_commit", acc_cyc, first_commit + 1);
    repeat (2 * FRAME + 4) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      send($urandom, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    repeat (2 * FRAME + 4) @(posedge clk);

    // Reset mid-slot at digit 5 with a word pending and another displayed.
    wait_pos(0);
    send(32'hCAFE_F00D, 8'h24);
    wait_pos(5 * DIV + 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_hold");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);

    send(32'h0000_00A0, 8'h00);
    repeat (2 * FRAME + 4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
